brnfck_mem_arb: RTL

- Two-requester arbiter that shares one single-port synchronous RAM (tape/program store) between the processor core and the host/debug loader.
- Grants one transaction at a time with round-robin priority, drives the RAM port from registered copies of the winning request, and returns a one-cycle ack plus read data to the winner.
- Sits between the datapath's memory interface, the host byte interface and the RAM macro.

---
 rtl/brnfck_arb_pkg.sv | 10 +
 rtl/brnfck_rr_pick.sv | 22 ++
 rtl/brnfck_mem_arb.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/brnfck_arb_pkg.sv
// Shared types and constants for the tape/program memory arbiter.
package brnfck_arb_pkg;

  localparam int unsigned RD_LAT_MAX = 15;
  localparam int unsigned LAT_W      = $clog2(RD_LAT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
  typedef enum logic       {CORE, HOST}               port_id_t;

endpackage

// File: rtl/brnfck_rr_pick.sv
// Combinational two-way round-robin picker; the requester that did not win last time has priority.
module brnfck_rr_pick
  import brnfck_arb_pkg::*;
(
  input  logic     c_req,
  input  logic     h_req,
  input  port_id_t last_grant,
  output logic     grant_valid,
  output port_id_t grant_id
);

  always_comb begin
    grant_valid = c_req | h_req;
    grant_id    = CORE;
    if (c_req && h_req) begin
      grant_id = (last_grant == CORE) ? HOST : CORE;
    end else if (h_req) begin
      grant_id = HOST;
    end
  end

endmodule

// File: rtl/brnfck_mem_arb.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the core and the host loader.
module brnfck_mem_arb
  import brnfck_arb_pkg::*;
#(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ack,
  output logic [DW-1:0] c_rdata,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_ack,
  output logic [DW-1:0] h_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  arb_state_t       state_q, state_d;
  port_id_t         last_grant_q, last_grant_d;
  port_id_t         id_q, id_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [DW-1:0]    c_rdata_q, c_rdata_d;
  logic [DW-1:0]    h_rdata_q, h_rdata_d;
  logic             c_ack_q, c_ack_d;
  logic             h_ack_q, h_ack_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic             busy_q, busy_d;
  logic             grant_valid;
  port_id_t         grant_id;
  logic             in_access;

  brnfck_rr_pick u_pick (
    .c_req       (c_req),
    .h_req       (h_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      last_grant_q <= HOST;
      id_q         <= CORE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      lat_cnt_q    <= '0;
      c_rdata_q    <= '0;
      h_rdata_q    <= '0;
      c_ack_q      <= 1'b0;
      h_ack_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      lat_cnt_q    <= lat_cnt_d;
      c_rdata_q    <= c_rdata_d;
      h_rdata_q    <= h_rdata_d;
      c_ack_q      <= c_ack_d;
      h_ack_q      <= h_ack_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
    end
  end

  // Next state, request latch and read-data capture
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    lat_cnt_d    = lat_cnt_q;
    c_rdata_d    = c_rdata_q;
    h_rdata_d    = h_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d      = ACCESS;
          last_grant_d = grant_id;
          id_d         = grant_id;
          if (grant_id == CORE) begin
            we_d    = c_we;
            addr_d  = c_addr;
            wdata_d = c_wdata;
          end else begin
            we_d    = h_we;
            addr_d  = h_addr;
            wdata_d = h_wdata;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          lat_cnt_d = LAT_W'(RD_LAT);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_W'(1);
        // <= guards against a zero count ever stalling the FSM
        if (lat_cnt_q <= LAT_W'(1)) begin
          state_d = RESP;
          if (id_q == CORE) c_rdata_d = mem_rdata;
          else              h_rdata_d = mem_rdata;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it
    in_access   = (state_d == ACCESS);
    mem_en_d    = in_access;
    mem_we_d    = in_access && we_d;
    mem_addr_d  = in_access ? addr_d  : '0;
    mem_wdata_d = in_access ? wdata_d : '0;
    c_ack_d     = (state_d == RESP) && (id_d == CORE);
    h_ack_d     = (state_d == RESP) && (id_d == HOST);
    busy_d      = (state_d != IDLE);
  end

  assign c_ack     = c_ack_q;
  assign h_ack     = h_ack_q;
  assign c_rdata   = c_rdata_q;
  assign h_rdata   = h_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule
